byte_mem_arbiter: RTL and testbench

//  Shares one byte-wide memory port between the bridge byte sequencer and a core-side requester.
//  The bridge sequencer runs fixed-cycle and cannot be stalled, so it has absolute priority.
//  The core side uses a valid/ready handshake. Each accepted request is buffered in a one-entry

---
 rtl/byte_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_byte_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mem_arbiter.sv
// byte_mem_arbiter
//   Shares one byte-wide memory port between the bridge byte sequencer and a
//   core-side requester. The bridge runs fixed-cycle and cannot be stalled, so
//   it always wins. Each core request is parked in a one-entry holding register.
//   It is issued in the first cycle the bridge leaves the port free. Core read
//   data returns through a tag pipe that matches the memory read latency.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   br_selected         bridge owns the memory port
//   br_mem_*            bridge address / strobes / write byte
//   br_mem_rd_data      read byte back to the bridge (unregistered)
//   core_valid/ready    core request handshake
//   core_wr/addr/wr_data  core request payload (core_wr=1 write, 0 read)
//   core_rd_valid/data  registered core read return (one-cycle pulse)
//   core_starved        sticky: a core request waited STARVE_LIMIT cycles
//   proto_err           sticky: bridge strobe seen while br_selected low
//   mem_*               shared byte memory port
`timescale 1ns/1ps
module byte_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              br_selected,
  input  logic [ADDR_W-1:0] br_mem_addr,
  input  logic              br_mem_wr,
  input  logic              br_mem_rd,
  input  logic [7:0]        br_mem_wr_data,
  output logic [7:0]        br_mem_rd_data,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_wr_data,
  output logic              core_rd_valid,
  output logic [7:0]        core_rd_data,
  output logic              core_starved,
  output logic              proto_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                    hold_valid;
  logic                    hold_wr;
  logic [ADDR_W-1:0]       hold_addr;
  logic [7:0]              hold_data;
  logic                    br_strobe;
  logic                    issue;
  logic                    accept;
  logic [READ_LATENCY-1:0] tag;
  logic [CNT_W-1:0]        wait_cnt;

  assign br_strobe      = br_mem_wr | br_mem_rd;
  // A bridge strobe blocks the core even when br_selected is (wrongly) low,
  // so the two never drive the memory in the same cycle.
  assign issue          = hold_valid & ~br_selected & ~br_strobe;
  assign core_ready     = ~hold_valid | issue;
  assign accept         = core_valid & core_ready;
  assign br_mem_rd_data = mem_rd_data;

  // Memory mux: bridge, core issue, or idle (core payload parked on the bus).
  always_comb begin
    mem_addr    = hold_addr;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr_data = hold_data;
    if (br_selected || br_strobe) begin
      mem_addr    = br_mem_addr;
      mem_wr      = br_mem_wr;
      mem_rd      = br_mem_rd;
      mem_wr_data = br_mem_wr_data;
    end else if (issue) begin
      mem_wr = hold_wr;
      mem_rd = ~hold_wr;
    end
  end

  // Holding register control. An accept coinciding with an issue keeps the
  // entry occupied with the new request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
    end else if (issue) begin
      hold_valid <= 1'b0;
    end
  end

  // Holding register payload; only meaningful while hold_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_wr   <= core_wr;
      hold_addr <= core_addr;
      hold_data <= core_wr_data;
    end
  end

  // Read return: the tag reaches the last stage in the cycle the memory data
  // is valid; data is captured there and the valid pulse follows a cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag           <= '0;
      core_rd_valid <= 1'b0;
      core_rd_data  <= 8'h00;
    end else begin
      tag[0] <= issue & ~hold_wr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
      core_rd_valid <= tag[READ_LATENCY-1];
      if (tag[READ_LATENCY-1]) begin
        core_rd_data <= mem_rd_data;
      end
    end
  end

  // Starvation tracking; core_starved rises together with the counter
  // reaching the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt     <= '0;
      core_starved <= 1'b0;
    end else begin
      if (issue) begin
        wait_cnt <= '0;
      end else if (hold_valid && (wait_cnt != CNT_W'(STARVE_LIMIT))) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
        if (wait_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
          core_starved <= 1'b1;
        end
      end
    end
  end

  // Protocol error: bridge strobe without ownership.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (br_strobe && !br_selected) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_mem_arbiter.sv
`timescale 1ns/1ps
module tb_byte_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              br_selected = 1'b0;
  logic [ADDR_W-1:0] br_mem_addr = '0;
  logic              br_mem_wr = 1'b0;
  logic              br_mem_rd = 1'b0;
  logic [7:0]        br_mem_wr_data = 8'h00;
  logic [7:0]        br_mem_rd_data;
  logic              core_valid = 1'b0;
  logic              core_ready;
  logic              core_wr = 1'b0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic [7:0]        core_wr_data = 8'h00;
  logic              core_rd_valid;
  logic [7:0]        core_rd_data;
  logic              core_starved;
  logic              proto_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic              mem_rd;
  logic [7:0]        mem_wr_data;
  logic [7:0]        mem_rd_data = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  byte_mem_arbiter #(
    .ADDR_W(ADDR_W), .READ_LATENCY(1), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .br_selected(br_selected), .br_mem_addr(br_mem_addr),
    .br_mem_wr(br_mem_wr), .br_mem_rd(br_mem_rd),
    .br_mem_wr_data(br_mem_wr_data), .br_mem_rd_data(br_mem_rd_data),
    .core_valid(core_valid), .core_ready(core_ready), .core_wr(core_wr),
    .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
    .core_starved(core_starved), .proto_err(proto_err),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Byte RAM with one-cycle read latency on the shared port.
  logic [7:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr[7:0]] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= ram[mem_addr[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    br_selected    = 1'b0;
    br_mem_wr      = 1'b0;
    br_mem_rd      = 1'b0;
    br_mem_addr    = '0;
    br_mem_wr_data = 8'h00;
    core_valid     = 1'b0;
    core_wr        = 1'b0;
    core_addr      = '0;
    core_wr_data   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Writes a byte into the RAM through the bridge path.
  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    br_selected    = 1'b1;
    br_mem_wr      = 1'b1;
    br_mem_addr    = {24'h0, a};
    br_mem_wr_data = d;
    step();
    br_mem_wr   = 1'b0;
    br_selected = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", core_ready); end
    n_checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0/0", mem_rd, mem_wr); end
    n_checks++; if (core_rd_valid !== 1'b0 || core_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got v=%b d=%h want 0/00", core_rd_valid, core_rd_data); end
    n_checks++; if (core_starved !== 1'b0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got st=%b pe=%b want 0/0", core_starved, proto_err); end
  endtask

  task automatic test_core_read();
    do_reset();
    preload(8'h10, 8'hA5);
    core_valid = 1'b1; core_wr = 1'b0; core_addr = 32'h10;
    #1;
    n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL rd_accept: got %b want 1", core_ready); end
    step(); core_valid = 1'b0; #1;
    n_checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL rd_issue: got rd=%b wr=%b a=%h want 1/0/10", mem_rd, mem_wr, mem_addr); end
    step();
    n_checks++; if (core_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early: got %b want 0", core_rd_valid); end
    step();
    n_checks++; if (core_rd_valid !== 1'b1 || core_rd_data !== 8'hA5) begin n_fail++; $display("FAIL rd_return: got v=%b d=%h want 1/a5", core_rd_valid, core_rd_data); end
    step();
    n_checks++; if (core_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse: got %b want 0", core_rd_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    core_valid = 1'b1; core_wr = 1'b1; core_addr = 32'h20; core_wr_data = 8'h5A;
    #1;
    n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", core_ready); end
    step();
    core_wr = 1'b0; core_addr = 32'h20;
    #1;
    n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", core_ready); end
    n_checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h20 || mem_wr_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_write: got wr=%b rd=%b a=%h d=%h want 1/0/20/5a", mem_wr, mem_rd, mem_addr, mem_wr_data); end
    step(); core_valid = 1'b0; #1;
    n_checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h20 || core_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_read: got rd=%b wr=%b a=%h rdy=%b want 1/0/20/1", mem_rd, mem_wr, mem_addr, core_ready); end
    step();
    step();
    n_checks++; if (core_rd_valid !== 1'b1 || core_rd_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_return: got v=%b d=%h want 1/5a", core_rd_valid, core_rd_data); end
  endtask

  task automatic test_bridge_priority();
    do_reset();
    br_selected = 1'b1; br_mem_addr = 32'h99;
    core_valid = 1'b1; core_wr = 1'b1; core_addr = 32'h30; core_wr_data = 8'h33;
    #1;
    n_checks++; if (core_ready !== 1'b1 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL pri_accept: got rdy=%b wr=%b want 1/0", core_ready, mem_wr); end
    step(); core_valid = 1'b0; #1;
    for (int i = 1; i < 12; i++) begin
      n_checks++;
      if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || core_ready !== 1'b0 || mem_addr !== 32'h99) begin
        n_fail++;
        $display("FAIL pri_hold cycle %0d: got wr=%b rd=%b rdy=%b a=%h want 0/0/0/99", i, mem_wr, mem_rd, core_ready, mem_addr);
      end
      step();
    end
    br_selected = 1'b0;
    #1;
    n_checks++; if (mem_wr !== 1'b1 || mem_addr !== 32'h30 || mem_wr_data !== 8'h33 || core_ready !== 1'b1) begin n_fail++; $display("FAIL pri_issue: got wr=%b a=%h d=%h rdy=%b want 1/30/33/1", mem_wr, mem_addr, mem_wr_data, core_ready); end
  endtask

  task automatic test_starvation();
    do_reset();
    preload(8'h40, 8'h77);
    br_selected = 1'b1;
    core_valid = 1'b1; core_wr = 1'b0; core_addr = 32'h40;
    #1;
    n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL st_accept: got %b want 1", core_ready); end
    step(); core_valid = 1'b0; #1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (core_starved !== 1'b0) begin n_fail++; $display("FAIL st_early cycle %0d: got %b want 0", i, core_starved); end
      step();
    end
    n_checks++; if (core_starved !== 1'b1) begin n_fail++; $display("FAIL st_rise: got %b want 1", core_starved); end
    repeat (5) step();
    br_selected = 1'b0;
    #1;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h40 || core_starved !== 1'b1) begin n_fail++; $display("FAIL st_issue: got rd=%b a=%h st=%b want 1/40/1", mem_rd, mem_addr, core_starved); end
    step();
    n_checks++; if (core_starved !== 1'b1 || core_ready !== 1'b1) begin n_fail++; $display("FAIL st_sticky: got st=%b rdy=%b want 1/1", core_starved, core_ready); end
    step();
    n_checks++; if (core_rd_valid !== 1'b1 || core_rd_data !== 8'h77) begin n_fail++; $display("FAIL st_return: got v=%b d=%h want 1/77", core_rd_valid, core_rd_data); end
  endtask

  task automatic test_proto_err();
    do_reset();
    br_selected = 1'b0; br_mem_wr = 1'b1; br_mem_addr = 32'h50; br_mem_wr_data = 8'hC3;
    #1;
    n_checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h50 || mem_wr_data !== 8'hC3) begin n_fail++; $display("FAIL pe_pass: got wr=%b rd=%b a=%h d=%h want 1/0/50/c3", mem_wr, mem_rd, mem_addr, mem_wr_data); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL pe_before: got %b want 0", proto_err); end
    step(); br_mem_wr = 1'b0; #1;
    n_checks++; if (proto_err !== 1'b1 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL pe_set: got pe=%b wr=%b want 1/0", proto_err, mem_wr); end
    n_checks++; if (ram[8'h50] !== 8'hC3) begin n_fail++; $display("FAIL pe_ram: got %h want c3", ram[8'h50]); end
    repeat (3) step();
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL pe_sticky: got %b want 1", proto_err); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    core_valid = 1'b1; core_wr = 1'b0; core_addr = 32'h10;
    step(); core_valid = 1'b0; #1;
    n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL mid_issue: got %b want 1", mem_rd); end
    step();
    reset_n = 1'b0;
    #1;
    n_checks++; if (core_ready !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl: got rdy=%b rd=%b wr=%b want 1/0/0", core_ready, mem_rd, mem_wr); end
    n_checks++; if (core_rd_valid !== 1'b0 || core_rd_data !== 8'h00 || core_starved !== 1'b0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_out: got v=%b d=%h st=%b pe=%b want 0/00/0/0", core_rd_valid, core_rd_data, core_starved, proto_err); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (core_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_noreturn cycle %0d: got %b want 0", i, core_rd_valid); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_back_to_back();
    test_bridge_priority();
    test_starvation();
    test_proto_err();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
